// File: rtl/conv_stage_seq.sv
// conv_stage_seq: sequential K x K x CH convolution stage.
// Loads a DIM x DIM x CH tensor from feature BRAM into a local buffer, then
// computes NF*OUT_DIM^2 results with one shared MAC, streamed out valid/ready.
module conv_stage_seq #(
  parameter int DATA_W = 16,
  parameter int W_W    = 17,
  parameter int DIM    = 8,
  parameter int CH     = 3,
  parameter int K      = 3,
  parameter int NF     = 4,
  parameter int ACC_W  = 36,
  localparam int OUT_DIM = DIM - K + 1,
  localparam int N_IN    = DIM * DIM * CH,
  localparam int AW      = $clog2(N_IN),
  localparam int WAW     = $clog2(NF * K * K * CH),
  localparam int FW      = (NF > 1) ? $clog2(NF) : 1,
  localparam int RW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1,
  localparam int KW      = (K > 1) ? $clog2(K) : 1,
  localparam int CW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    relu_en,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [AW-1:0]           rd_addr,
  input  logic [DATA_W-1:0]       rd_data,
  output logic [WAW-1:0]          w_addr,
  input  logic signed [W_W-1:0]   w_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [FW-1:0]           out_filter,
  output logic [RW-1:0]           out_row,
  output logic [RW-1:0]           out_col
);

  localparam int PRW = DATA_W + 1 + W_W;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_EMIT, S_DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]       buf_mem [N_IN];
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic                    relu_q;
  logic signed [ACC_W-1:0] acc;
  logic [FW-1:0]           f;
  logic [RW-1:0]           r, c;
  logic [KW-1:0]           kr, kc;
  logic [CW-1:0]           ch;

  logic [AW-1:0]           buf_idx;
  logic signed [DATA_W:0]  din;
  logic signed [PRW-1:0]   prod;
  logic                    load_last, mac_last, pos_last;

  assign load_last = wr_en && (wr_addr == AW'(N_IN - 1));
  assign mac_last  = (kr == KW'(K - 1)) && (kc == KW'(K - 1)) && (ch == CW'(CH - 1));
  assign pos_last  = (f == FW'(NF - 1)) && (r == RW'(OUT_DIM - 1)) && (c == RW'(OUT_DIM - 1));

  // Buffer address, weight address and signed MAC product for the current step
  always_comb begin
    buf_idx = AW'(((AW'(r) + AW'(kr)) * AW'(DIM) + AW'(c) + AW'(kc)) * AW'(CH) + AW'(ch));
    w_addr  = WAW'(((WAW'(f) * WAW'(K) + WAW'(kr)) * WAW'(K) + WAW'(kc)) * WAW'(CH) + WAW'(ch));
    din     = signed'({1'b0, buf_mem[buf_idx]});
    prod    = din * w_data;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: if (load_last) state_nxt = S_MAC;
      S_MAC:  if (mac_last) state_nxt = S_EMIT;
      S_EMIT: if (out_ready) state_nxt = pos_last ? S_DONE : S_MAC;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status and stream outputs decoded from state and datapath registers
  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    out_valid  = (state == S_EMIT);
    out_data   = (relu_q && acc[ACC_W-1]) ? '0 : acc;
    out_filter = f;
    out_row    = r;
    out_col    = c;
  end

  // Load sequencing, MAC accumulation and loop counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      relu_q  <= 1'b0;
      acc     <= '0;
      f       <= '0;
      r       <= '0;
      c       <= '0;
      kr      <= '0;
      kc      <= '0;
      ch      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            relu_q  <= relu_en;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            wr_en   <= 1'b0;
            acc     <= '0;
            f       <= '0;
            r       <= '0;
            c       <= '0;
            kr      <= '0;
            kc      <= '0;
            ch      <= '0;
          end
        end
        S_LOAD: begin
          // Read data returns one cycle after the address, so the write
          // side trails the read side by one registered stage.
          wr_en   <= rd_en;
          wr_addr <= rd_addr;
          if (rd_en) begin
            if (rd_addr == AW'(N_IN - 1)) begin
              rd_en   <= 1'b0;
              rd_addr <= '0;
            end else begin
              rd_addr <= rd_addr + AW'(1);
            end
          end
          acc <= '0;
        end
        S_MAC: begin
          acc <= acc + ACC_W'(prod);
          if (ch == CW'(CH - 1)) begin
            ch <= '0;
            if (kc == KW'(K - 1)) begin
              kc <= '0;
              kr <= (kr == KW'(K - 1)) ? '0 : kr + KW'(1);
            end else begin
              kc <= kc + KW'(1);
            end
          end else begin
            ch <= ch + CW'(1);
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            acc <= '0;
            if (c == RW'(OUT_DIM - 1)) begin
              c <= '0;
              if (r == RW'(OUT_DIM - 1)) begin
                r <= '0;
                f <= (f == FW'(NF - 1)) ? '0 : f + FW'(1);
              end else begin
                r <= r + RW'(1);
              end
            end else begin
              c <= c + RW'(1);
            end
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

  // Input tensor buffer; contents need no reset since every frame reloads it
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[wr_addr] <= rd_data;
  end

endmodule

// File: tb/tb_conv_stage_seq.sv
// Directed self-checking bench for conv_stage_seq at default parameters.
module tb_conv_stage_seq;

  localparam int NRES    = 144;
  localparam int LATENCY = 4226;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               relu_en;
  logic               busy;
  logic               done;
  logic               rd_en;
  logic [7:0]         rd_addr;
  logic [15:0]        rd_data;
  logic [6:0]         w_addr;
  logic signed [16:0] w_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [35:0] out_data;
  logic [1:0]         out_filter;
  logic [2:0]         out_row;
  logic [2:0]         out_col;

  int checks = 0;
  int errors = 0;

  // Memory models: data mode and weight mode selected per frame
  bit          ramp_mode;
  logic [15:0] data_val;
  bit          impulse_mode;
  logic signed [16:0] w_val;

  conv_stage_seq #(.DATA_W(16), .W_W(17), .DIM(8), .CH(3), .K(3), .NF(4), .ACC_W(36)) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_filter(out_filter), .out_row(out_row), .out_col(out_col)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= ramp_mode ? {8'd0, rd_addr} : data_val;
  end

  always_comb begin
    if (impulse_mode) w_data = ((int'(w_addr) % 27) == 0) ? 17'sd1 : 17'sd0;
    else              w_data = w_val;
  end

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame: start, optional mid-frame stimulus, check every result
  task automatic run_frame(input logic signed [63:0] exp_c, input bit ramp, input bit relu,
                           input int rmode, input bit toggle, input bit poke, input bit chk_lat);
    int idx = 0, cyc = 0, stalls = 0;
    int ef = 0, er = 0, ec = 0;
    bit fin = 0, prev_stall = 0;
    logic signed [63:0] e;
    @(negedge clk);
    relu_en = relu;
    start   = 1'b1;
    for (int n = 0; n < 20000 && !fin; n++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        chk("load_rd_en", rd_en, 1);
        chk("load_addr0", rd_addr, 0);
        chk("busy_load", busy, 1);
      end
      if (poke && cyc == 5) start = 1'b1;
      if (poke && cyc == 6) start = 1'b0;
      if (toggle && cyc > 1) relu_en = ~relu_en;
      if (rmode == 0)                   out_ready = 1'b1;
      else if (idx == 0 && stalls < 10) out_ready = 1'b0;
      else                              out_ready = ($urandom_range(0, 3) != 0);
      if (prev_stall) chk("valid_held", out_valid, 1);
      prev_stall = 0;
      if (out_valid) begin
        if (idx >= NRES) begin
          chk("extra_result", idx, NRES - 1);
        end else begin
          e = ramp ? 64'((er * 8 + ec) * 3) : exp_c;
          chk("out_data", out_data, e);
          chk("out_filter", out_filter, ef);
          chk("out_row", out_row, er);
          chk("out_col", out_col, ec);
        end
        if (out_ready) begin
          idx++;
          if (ec == 5) begin
            ec = 0;
            if (er == 5) begin er = 0; ef++; end
            else er++;
          end else ec++;
        end else begin
          if (idx == 0) stalls++;
          prev_stall = 1;
        end
      end
      if (done) fin = 1;
    end
    if (!fin) chk("timeout_done", 0, 1);
    chk("result_count", idx, NRES);
    if (chk_lat) chk("latency", cyc, LATENCY);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    if (poke) begin
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        chk("no_second_frame", busy, 0);
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; relu_en = 1'b0; out_ready = 1'b1;
    ramp_mode = 0; data_val = 16'd1; impulse_mode = 0; w_val = 17'sd1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b1;

    // All ones: every result 27, latency checked
    run_frame(27, 0, 0, 0, 0, 0, 1);

    // Ramp data with impulse kernel
    ramp_mode = 1; impulse_mode = 1;
    run_frame(0, 1, 0, 0, 0, 0, 1);

    // ReLU off / on (with mid-frame toggling)
    ramp_mode = 0; impulse_mode = 0; data_val = 16'd5; w_val = -17'sd1;
    run_frame(-64'sd135, 0, 0, 0, 0, 0, 1);
    run_frame(0, 0, 1, 0, 1, 0, 1);
    run_frame(-64'sd135, 0, 0, 0, 1, 0, 1);

    // Backpressure: 10-cycle stall on first result, random afterwards
    data_val = 16'd1; w_val = 17'sd1;
    run_frame(27, 0, 0, 1, 0, 0, 0);

    // Accumulator wrap
    data_val = 16'hFFFF; w_val = 17'sd65535;
    run_frame(-64'sd21478375397, 0, 0, 0, 0, 0, 1);

    // Reset mid-MAC
    data_val = 16'd1; w_val = 17'sd1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    chk("busy_before_reset", busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_filter", out_filter, 0);
    chk("mid_rst_row", out_row, 0);
    chk("mid_rst_col", out_col, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_frame(27, 0, 0, 0, 0, 0, 1);

    // start pulsed during LOAD and DONE must be ignored
    run_frame(27, 0, 0, 0, 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_stage_seq.md
# conv_stage_seq

Parametrised sequential convolution stage for the CNN datapath. It loads one DIM×DIM×CH input tensor from the upstream feature BRAM into a local buffer, then convolves it with NF filters of size K×K×CH, using one time-multiplexed MAC. Results leave as a valid/ready stream, one per cycle at best, replacing the fixed 8×8×3 / 4-filter stage and its wide parallel output array. Optional ReLU is selected per frame.

## Interface
Parameters:
- DATA_W, 16: BRAM word width. Input is unsigned and zero-extended to DATA_W+1 signed.
- W_W, 17: signed weight width.
- DIM, 8: input rows = columns.
- CH, 3: input channels.
- K, 3: kernel size. OUT_DIM = DIM-K+1.
- NF, 4: number of filters.
- ACC_W, 36: signed accumulator and output width.

Ports:
- clk  in  1  single clock. All state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  frame request. Sampled only in IDLE.
- relu_en  in  1  latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result handshake.
- rd_en  out  1  BRAM read enable.
- rd_addr  out  clog2(DIM*DIM*CH)  BRAM address = (row*DIM+col)*CH+ch.
- rd_data  in  DATA_W  BRAM data, valid 1 cycle after rd_en.
- w_addr  out  clog2(NF*K*K*CH)  weight ROM address = ((f*K+kr)*K+kc)*CH+ch.
- w_data  in  W_W  signed weight, combinational from w_addr in the same cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  ACC_W  signed result.
- out_filter / out_row / out_col  out  clog2 widths  result coordinates.

## Operation
- States: IDLE → LOAD → MAC → EMIT → (MAC | DONE) → IDLE.
- IDLE: when start=1, latch relu_en, clear counters, and go to LOAD.
- LOAD:
  - rd_en=1 for N_IN=DIM*DIM*CH consecutive cycles, with rd_addr 0..N_IN-1 in order.
  - rd_data is written to buffer[rd_addr delayed 1 cycle].
  - The cycle after the last data is captured, go to MAC with acc=0.
- MAC:
  - Loop order, outer to inner: f, r, c (output position), then kr, kc, ch (ch fastest).
  - Each cycle: acc += buffer[(r+kr, c+kc, ch)] × w_data.
  - K*K*CH cycles per output, then go to EMIT.
- EMIT:
  - out_valid=1, with out_data = (relu_en && acc<0) ? 0 : acc, plus coordinates.
  - out_data and coordinates stay stable until out_ready=1.
  - On the handshake, advance c, then r, then f.
  - If f=NF-1, r=c=OUT_DIM-1, go to DONE. Otherwise clear acc and return to MAC.
- DONE: done=1 for one cycle, then IDLE.
- Result order: filter-major, then row, then col. NF*OUT_DIM² results per frame (144 at defaults).
- Arithmetic:
  - Product is (DATA_W+1)×W_W signed, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W, with no saturation.
- start while busy is ignored, including in the DONE cycle.
- relu_en changes mid-frame have no effect.

## Timing
- Reset values (async assert, any state): state IDLE; busy, done, rd_en, out_valid = 0; rd_addr, out_data, out_filter, out_row, out_col, acc and all counters = 0.
- Reset mid-frame aborts immediately. The buffer contents are don't-care; the next frame reloads them.
- start accepted at edge T: LOAD (rd_en=1, rd_addr=0) is visible in cycle T+1. The last rd_addr is issued at T+N_IN.
- MAC begins at T+N_IN+2.
- Per result: K*K*CH MAC cycles plus at least 1 EMIT cycle.
- With out_ready held high, frame latency from start to done = N_IN + 1 + NF*OUT_DIM²*(K*K*CH+1) + 1 cycles. At defaults that is 192 + 1 + 144×28 + 1 = 4226.
- out_valid never drops without a handshake. No result is lost or duplicated under backpressure.

## Test plan
- **All-ones:** rd_data=1 and every weight=1, out_ready=1.
  - Exactly 144 results, each 27, coordinates in f, r, c order.
  - done 4226 cycles after start.
- **Ramp/impulse:** rd_data = address value; weight=1 only at kr=kc=ch=0, else 0.
  - out(f,r,c) = (r*8+c)*3 for all f.
- **ReLU:** rd_data=5, weights=-1.
  - relu_en=0 gives -135 for every result.
  - relu_en=1 gives 0.
  - Toggling relu_en mid-frame changes nothing.
- **Backpressure:** out_ready low for 10 cycles at the first result and randomly afterwards.
  - out_valid held, data and coordinates stable during stalls.
  - Still exactly 144 results.
- **Wrap:** rd_data=65535, weights=65535, relu_en=0.
  - Every result = -21478375397 (27×65535² mod 2^36, read as signed).
- **Reset and start robustness:**
  - Assert reset mid-MAC: all outputs go to their reset values at once. A new start then yields a clean 144-result frame.
  - start pulsed during LOAD and DONE is ignored: one done, no second frame.
